// File: rtl/seq_job_sched.sv
// rtl/seq_job_sched.sv - round-robin scheduler sharing one SEQ solver engine between requesters
module seq_job_sched #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  input  logic               req_valid,
  input  logic [4:0]         req_in,
  input  logic [4:0]         req_p1,
  input  logic [1:0]         req_mode,
  output logic               eng_in_valid,
  output logic [4:0]         eng_in,
  output logic [4:0]         eng_in_p1,
  output logic [1:0]         eng_mode,
  input  logic               eng_out_valid,
  input  logic [2:0]         eng_circle,
  input  logic [7:0]         eng_value,
  output logic               rsp_valid,
  output logic [1:0]         rsp_id,
  output logic [2:0]         rsp_circle,
  output logic [7:0]         rsp_value,
  output logic               rsp_last,
  output logic               timeout,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PLAY, S_WAIT, S_DRAIN, S_GAP
  } state_t;

  localparam logic [4:0] LAST_BEAT = 5'd23;
  localparam logic [3:0] MAX_RSP   = 4'd8;

  state_t               state_q, state_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [1:0]           owner_q, owner_d;
  logic [4:0]           wr_q, wr_d;
  logic [4:0]           rd_q, rd_d;
  logic [7:0]           wcnt_q, wcnt_d;
  logic [3:0]           ocnt_q, ocnt_d;
  logic [4:0]           p1_q, p1_d;
  logic [1:0]           mode_q, mode_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 eng_in_valid_q, eng_in_valid_d;
  logic [4:0]           eng_in_q, eng_in_d;
  logic [4:0]           eng_in_p1_q, eng_in_p1_d;
  logic [1:0]           eng_mode_q, eng_mode_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [1:0]           rsp_id_q, rsp_id_d;
  logic [2:0]           rsp_circle_q, rsp_circle_d;
  logic [7:0]           rsp_value_q, rsp_value_d;
  logic [4:0]           job_buf_q [0:23];
  logic [4:0]           job_buf_d [0:23];

  logic                 win_hit;
  logic [1:0]           win_idx;
  logic [2:0]           cand;
  logic                 owner_req;
  logic [1:0]           ptr_after;
  logic                 wait_expired;

  // Round-robin winner: first requester at or after ptr, wrapping at NUM_REQ
  always_comb begin
    win_hit = 1'b0;
    win_idx = 2'd0;
    cand    = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + 3'(i);
      if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!win_hit && req[r] && cand == 3'(r)) begin
          win_hit = 1'b1;
          win_idx = 2'(r);
        end
      end
    end
  end

  // Owner's live request bit (abort detection) and the pointer value used when the job ends
  always_comb begin
    owner_req = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (owner_q == 2'(r)) owner_req = req[r];
    end
    ptr_after    = (owner_q == 2'(NUM_REQ - 1)) ? 2'd0 : owner_q + 2'd1;
    wait_expired = (state_q == S_WAIT) && (wcnt_q == 8'(TIMEOUT - 1)) && !eng_out_valid;
  end

  // Next-state and registered-output logic for the job FSM
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    owner_d        = owner_q;
    wr_d           = wr_q;
    rd_d           = rd_q;
    wcnt_d         = wcnt_q;
    ocnt_d         = ocnt_q;
    p1_d           = p1_q;
    mode_d         = mode_q;
    gnt_d          = gnt_q;
    eng_in_valid_d = eng_in_valid_q;
    eng_in_d       = eng_in_q;
    eng_in_p1_d    = eng_in_p1_q;
    eng_mode_d     = eng_mode_q;
    rsp_valid_d    = 1'b0;
    rsp_id_d       = rsp_id_q;
    rsp_circle_d   = rsp_circle_q;
    rsp_value_d    = rsp_value_q;
    job_buf_d      = job_buf_q;

    case (state_q)
      S_IDLE: begin
        if (win_hit) begin
          state_d = S_LOAD;
          owner_d = win_idx;
          wr_d    = 5'd0;
          for (int r = 0; r < NUM_REQ; r++) gnt_d[r] = (win_idx == 2'(r));
        end
      end
      S_LOAD: begin
        if (!owner_req) begin
          // owner gave up mid-load: discard the partial job
          state_d = S_GAP;
          gnt_d   = '0;
          ptr_d   = ptr_after;
        end else if (req_valid) begin
          job_buf_d[wr_q] = req_in;
          if (wr_q == 5'd0) begin
            p1_d   = req_p1;
            mode_d = req_mode;
          end
          if (wr_q == LAST_BEAT) begin
            // first engine beat is launched on the same edge as the last accepted beat
            state_d        = S_PLAY;
            gnt_d          = '0;
            wr_d           = 5'd0;
            rd_d           = 5'd0;
            eng_in_valid_d = 1'b1;
            eng_in_d       = job_buf_q[0];
            eng_in_p1_d    = p1_q;
            eng_mode_d     = mode_q;
          end else begin
            wr_d = wr_q + 5'd1;
          end
        end
      end
      S_PLAY: begin
        if (rd_q == LAST_BEAT) begin
          state_d        = S_WAIT;
          eng_in_valid_d = 1'b0;
          wcnt_d         = 8'd0;
        end else begin
          rd_d     = rd_q + 5'd1;
          eng_in_d = job_buf_q[rd_q + 5'd1];
        end
      end
      S_WAIT: begin
        if (eng_out_valid) begin
          state_d      = S_DRAIN;
          rsp_valid_d  = 1'b1;
          rsp_id_d     = owner_q;
          rsp_circle_d = eng_circle;
          rsp_value_d  = eng_value;
          ocnt_d       = 4'd1;
        end else if (wait_expired) begin
          state_d = S_GAP;
          ptr_d   = ptr_after;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (eng_out_valid && ocnt_q != MAX_RSP) begin
          rsp_valid_d  = 1'b1;
          rsp_id_d     = owner_q;
          rsp_circle_d = eng_circle;
          rsp_value_d  = eng_value;
          ocnt_d       = ocnt_q + 4'd1;
        end else begin
          // burst over: engine went quiet or the 8-beat cap was hit; extras are dropped
          state_d = S_GAP;
          ptr_d   = ptr_after;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      ptr_q          <= 2'd0;
      owner_q        <= 2'd0;
      wr_q           <= 5'd0;
      rd_q           <= 5'd0;
      wcnt_q         <= 8'd0;
      ocnt_q         <= 4'd0;
      p1_q           <= 5'd0;
      mode_q         <= 2'd0;
      gnt_q          <= '0;
      eng_in_valid_q <= 1'b0;
      eng_in_q       <= 5'd0;
      eng_in_p1_q    <= 5'd0;
      eng_mode_q     <= 2'd0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 2'd0;
      rsp_circle_q   <= 3'd0;
      rsp_value_q    <= 8'd0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      owner_q        <= owner_d;
      wr_q           <= wr_d;
      rd_q           <= rd_d;
      wcnt_q         <= wcnt_d;
      ocnt_q         <= ocnt_d;
      p1_q           <= p1_d;
      mode_q         <= mode_d;
      gnt_q          <= gnt_d;
      eng_in_valid_q <= eng_in_valid_d;
      eng_in_q       <= eng_in_d;
      eng_in_p1_q    <= eng_in_p1_d;
      eng_mode_q     <= eng_mode_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_circle_q   <= rsp_circle_d;
      rsp_value_q    <= rsp_value_d;
    end
  end

  // Job buffer storage; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    job_buf_q <= job_buf_d;
  end

  assign gnt          = gnt_q;
  assign eng_in_valid = eng_in_valid_q;
  assign eng_in       = eng_in_q;
  assign eng_in_p1    = eng_in_p1_q;
  assign eng_mode     = eng_mode_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_circle   = rsp_circle_q;
  assign rsp_value    = rsp_value_q;
  // the presented beat is final when the engine has gone quiet or the cap is reached
  assign rsp_last     = rsp_valid_q && (!eng_out_valid || ocnt_q == MAX_RSP);
  assign timeout      = wait_expired;
  assign busy         = (state_q != S_IDLE);

endmodule
